// File: rtl/fp_to_int_converter_if.sv
// Handshake bundle between the FP convert datapath (master) and the
// binary32-to-integer converter (slave).
interface fp_to_int_converter_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] A;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            invalid;
    logic            inexact;

    modport master (
        output in_valid, A, out_ready,
        input  in_ready, out_valid, result, invalid, inexact
    );

    modport slave (
        input  in_valid, A, out_ready,
        output in_ready, out_valid, result, invalid, inexact
    );
endinterface

// File: rtl/fp_to_int_converter.sv
// Iterative binary32 -> signed 32-bit integer converter.
// One bit of shift per cycle; specials (NaN, Inf, out-of-range, zero and
// denormals) are resolved at accept time and go straight to DONE.
//
//  state | meaning
//  IDLE  | waiting for an operand, in_ready high
//  SHIFT | aligning the mantissa one bit per cycle (left or right)
//  ROUND | applying rounding and sign, computing inexact
//  DONE  | result/flags presented until out_ready
module fp_to_int_converter #(
    parameter int XLEN          = 32,
    parameter bit ROUND_NEAREST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    fp_to_int_converter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

    state_t          state_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [XLEN-1:0] result_q;
    logic            invalid_q;
    logic            inexact_q;
    logic [XLEN-1:0] mag_q;
    logic [4:0]      cnt_q;
    logic            sign_q;
    logic            left_q;
    logic            guard_q;
    logic            sticky_q;

    logic            sign_d;
    logic [7:0]      exp_d;
    logic [22:0]     frac_d;
    logic            special_d;
    logic [XLEN-1:0] spec_res_d;
    logic            spec_inv_d;
    logic            spec_inx_d;
    logic            left_d;
    logic [4:0]      cnt_d;
    logic            inc_d;
    logic [XLEN-1:0] mag_rnd_d;
    logic [XLEN-1:0] res_rnd_d;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.invalid   = invalid_q;
    assign bus.inexact   = inexact_q;

    // Decode the incoming operand: special-case outcome or shift direction/count.
    // Exponent compares are done on the biased field: E=150 is e=23, E=158 is e=31.
    always_comb begin
        sign_d     = bus.A[31];
        exp_d      = bus.A[30:23];
        frac_d     = bus.A[22:0];
        special_d  = 1'b0;
        spec_res_d = '0;
        spec_inv_d = 1'b0;
        spec_inx_d = 1'b0;
        left_d     = 1'b0;
        cnt_d      = 5'd0;
        if (exp_d == 8'hFF && frac_d != 23'd0) begin
            special_d  = 1'b1;
            spec_res_d = 32'h7FFF_FFFF;
            spec_inv_d = 1'b1;
        end else if (exp_d >= 8'd158) begin
            special_d = 1'b1;
            if (!sign_d) begin
                spec_res_d = 32'h7FFF_FFFF;
                spec_inv_d = 1'b1;
            end else begin
                // exactly -2^31 is representable; anything beyond saturates
                spec_res_d = 32'h8000_0000;
                spec_inv_d = (exp_d != 8'd158) || (frac_d != 23'd0);
            end
        end else if (exp_d == 8'd0) begin
            special_d  = 1'b1;
            spec_inx_d = (frac_d != 23'd0);
        end else if (exp_d > 8'd150) begin
            left_d = 1'b1;
            cnt_d  = 5'(exp_d - 8'd150);
        end else if (exp_d >= 8'd126) begin
            cnt_d = 5'(8'd150 - exp_d);
        end else begin
            // 25 right shifts push every mantissa bit past the guard into sticky
            cnt_d = 5'd25;
        end
    end

    // Rounding increment and sign application for the ROUND state.
    always_comb begin
        inc_d     = ROUND_NEAREST ? (guard_q & (sticky_q | mag_q[0])) : 1'b0;
        mag_rnd_d = mag_q + {{(XLEN-1){1'b0}}, inc_d};
        res_rnd_d = sign_q ? (~mag_rnd_d + 1'b1) : mag_rnd_d;
    end

    // Conversion FSM with registered handshake outputs and datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            invalid_q   <= 1'b0;
            inexact_q   <= 1'b0;
            mag_q       <= '0;
            cnt_q       <= 5'd0;
            sign_q      <= 1'b0;
            left_q      <= 1'b0;
            guard_q     <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        sign_q     <= sign_d;
                        left_q     <= left_d;
                        guard_q    <= 1'b0;
                        sticky_q   <= 1'b0;
                        mag_q      <= {8'd0, 1'b1, frac_d};
                        cnt_q      <= cnt_d;
                        if (special_d) begin
                            result_q    <= spec_res_d;
                            invalid_q   <= spec_inv_d;
                            inexact_q   <= spec_inx_d;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else if (cnt_d == 5'd0) begin
                            state_q <= ROUND;
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (left_q) begin
                        mag_q <= {mag_q[XLEN-2:0], 1'b0};
                    end else begin
                        mag_q    <= {1'b0, mag_q[XLEN-1:1]};
                        guard_q  <= mag_q[0];
                        sticky_q <= sticky_q | guard_q;
                    end
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_q <= ROUND;
                    end
                end
                ROUND: begin
                    result_q    <= res_rnd_d;
                    invalid_q   <= 1'b0;
                    inexact_q   <= guard_q | sticky_q;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_to_int_converter.sv
// Directed-vector bench for fp_to_int_converter (round-nearest and truncating builds).
module tb_fp_to_int_converter;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    fp_to_int_converter_if #(.XLEN(32)) bus ();
    fp_to_int_converter_if #(.XLEN(32)) bus_t ();

    fp_to_int_converter #(.XLEN(32), .ROUND_NEAREST(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fp_to_int_converter #(.XLEN(32), .ROUND_NEAREST(1'b0)) dut_trunc (
        .clk (clk),
        .rst (rst),
        .bus (bus_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] res;
        logic        inv;
        logic        inx;
        int          lat;
    } vec_t;

    vec_t vecs [16];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Present one operand on the main bus and wait (bounded) for its result.
    task automatic convert(input logic [31:0] a, output logic [31:0] res,
                           output logic inv, output logic inx, output int lat);
        check_eq("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        bus.A        = a;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.out_valid) check_eq("out_valid_timeout", 32'(bus.out_valid), 32'd1);
        res = bus.result;
        inv = bus.invalid;
        inx = bus.inexact;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check_eq("out_valid_after_consume", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic        iv;
        logic        ix;
        int          lat;

        n_tests = 0;
        n_fail  = 0;
        vecs[0]  = '{32'h404C_CCCD, 32'h0000_0003, 1'b0, 1'b1, 24};
        vecs[1]  = '{32'hC28C_3EFA, 32'hFFFF_FFBA, 1'b0, 1'b1, 19};
        vecs[2]  = '{32'hBF00_0000, 32'h0000_0000, 1'b0, 1'b1, 26};
        vecs[3]  = '{32'h4020_0000, 32'h0000_0002, 1'b0, 1'b1, 24};
        vecs[4]  = '{32'h4060_0000, 32'h0000_0004, 1'b0, 1'b1, 24};
        vecs[5]  = '{32'h4B80_0001, 32'h0100_0002, 1'b0, 1'b0, 3};
        vecs[6]  = '{32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 1};
        vecs[7]  = '{32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1};
        vecs[8]  = '{32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1};
        vecs[9]  = '{32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 1};
        vecs[10] = '{32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 1};
        vecs[11] = '{32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1};
        vecs[12] = '{32'hCF00_0001, 32'h8000_0000, 1'b1, 1'b0, 1};
        vecs[13] = '{32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 25};
        vecs[14] = '{32'h4B00_0000, 32'h0080_0000, 1'b0, 1'b0, 2};
        vecs[15] = '{32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1};

        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.A           = '0;
        bus.out_ready   = 1'b0;
        bus_t.in_valid  = 1'b0;
        bus_t.A         = '0;
        bus_t.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_result", bus.result, 32'd0);
        check_eq("rst_invalid", 32'(bus.invalid), 32'd0);
        check_eq("rst_inexact", 32'(bus.inexact), 32'd0);

        // Back-to-back vectors: each starts right after the previous handshake.
        for (int i = 0; i < 16; i++) begin
            convert(vecs[i].a, r, iv, ix, lat);
            check_eq($sformatf("v%0d_result", i), r, vecs[i].res);
            check_eq($sformatf("v%0d_invalid", i), 32'(iv), 32'(vecs[i].inv));
            check_eq($sformatf("v%0d_inexact", i), 32'(ix), 32'(vecs[i].inx));
            check_eq($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            consume();
        end

        // Back-pressure: hold DONE for five cycles.
        convert(32'h4020_0000, r, iv, ix, lat);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check_eq("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check_eq("bp_result", bus.result, 32'd2);
            check_eq("bp_inexact", 32'(bus.inexact), 32'd1);
            check_eq("bp_invalid", 32'(bus.invalid), 32'd0);
            check_eq("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        consume();

        // Truncating build: 3.5 -> 3.
        bus_t.A        = 32'h4060_0000;
        bus_t.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_t.in_valid = 1'b0;
        lat = 1;
        while (!bus_t.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("trunc_out_valid", 32'(bus_t.out_valid), 32'd1);
        check_eq("trunc_result", bus_t.result, 32'd3);
        check_eq("trunc_inexact", 32'(bus_t.inexact), 32'd1);
        check_eq("trunc_latency", 32'(lat), 32'd24);
        bus_t.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_t.out_ready = 1'b0;

        // Reset in the middle of a right-shift sequence.
        bus.A        = 32'h404C_CCCD;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_eq("mid_in_ready_busy", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("mid_rst_result", bus.result, 32'd0);
        check_eq("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (30) @(posedge clk);
        #1;
        check_eq("mid_rst_no_output", 32'(bus.out_valid), 32'd0);

        convert(32'hC28C_3EFA, r, iv, ix, lat);
        check_eq("post_rst_result", r, 32'hFFFF_FFBA);
        check_eq("post_rst_inexact", 32'(ix), 32'd1);
        check_eq("post_rst_latency", 32'(lat), 32'd19);
        consume();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
